cache_req_arbiter: RTL and testbench
====================================

// Module: cache_req_arbiter
// PURPOSE
// - Shares one cache_system_* port (direct/2-way/4-way, same 11-bit addr/read/l1_hit/l2_hit I/F) between NREQ requesters.
// - Round-robin grant; sequences read strobe and response window; returns data and hit flags to the granted requester.
// - Keeps saturating hit/miss counters and a weighted-cost accumulator (AMAT numerator) for the analysis benches.
// PARAMETERS
// NREQ      2    number of requesters (2..4)
// ADDR_W    11   address width
// DATA_W    32   cache read data width (11 for direct/2-way systems)
// RESP_LAT  1    cycles from read-strobe cycle to valid cache outputs (>=1)
// CNT_W     16   width of each event counter
// COST_W    24   width of cost accumulator
// L1_COST   1    cost added per L1 hit
// L2_COST   10   cost added per L2 hit (L1 miss)
// MEM_COST  100  cost added per miss in both levels
// PORTS
// clk           in   1              clock, rising edge
// rst           in   1              asynchronous, active-low reset (rst==0 resets)
// req_valid     in   NREQ           per-requester request
// req_addr      in   NREQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
// req_ready     out  NREQ           one-hot accept; transfer when valid&ready
// rsp_valid     out  NREQ           one-hot, 1-cycle response pulse
// rsp_data      out  DATA_W         read data of the current response
// rsp_l1_hit    out  1              L1 hit flag of the current response
// rsp_l2_hit    out  1              L2 hit flag of the current response
// cache_read    out  1              read strobe to cache system
// cache_addr    out  ADDR_W         address to cache system
// cache_data    in   DATA_W         cache read_data
// cache_l1_hit  in   1              cache l1_hit
// cache_l2_hit  in   1              cache l2_hit
// stat_clear    in   1              synchronous clear of all stat outputs
// stat_l1_hits  out  CNT_W          L1 hit count
// stat_l2_hits  out  CNT_W          L2-only hit count
// stat_misses   out  CNT_W          miss count
// stat_cost     out  COST_W         sum of per-access costs
// BEHAVIOUR
// - Reset: state IDLE, rr pointer=NREQ-1 (req0 first priority); all registered outputs 0; req_ready forced 0 while rst==0.
// - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// - IDLE: grant g = first valid requester searching from pointer+1 (mod NREQ); req_ready[g]=1 combinationally, only in IDLE.
//   On valid&ready latch addr and g, go ISSUE. No valid: stay IDLE, ready all 0.
// - ISSUE: cache_read=1 exactly this cycle; cache_addr=latched addr; go WAIT with wait counter=RESP_LAT-1.
// - WAIT: cache_read=0, cache_addr held; when counter==0 sample cache_data/l1/l2 into rsp regs and go RESP; else decrement.
// - RESP: rsp_valid[g]=1 one cycle; pointer<=g; counters updated; go IDLE. Throughput: 1 access per RESP_LAT+3 cycles.
// - rsp_data/rsp_l1_hit/rsp_l2_hit hold last sampled values between responses; cache_addr holds last address.
// - Classification: l1_hit=1 -> L1 (even if l2_hit=1); else l2_hit -> L2; else miss. Cost adds matching *_COST.
// - Counters and stat_cost saturate at all-ones; never wrap.
// - stat_clear in RESP cycle: clear wins, that access not counted. stat_clear never affects FSM or responses.
// - Requester may drop req_valid before ready without penalty; addr must be stable while valid&~ready.
// - Async reset mid-access aborts it: no rsp_valid, no count, cache_read drops immediately.
// STRUCTURE
// - cache_sim_defs.vh: FSM state encodings (IDLE=0,ISSUE=1,WAIT=2,RESP=3), default cost constants, ADDR_W default.
// - Sub-module rr_arbiter (NREQ): inputs req, pointer; output one-hot grant; purely combinational.
// - Counter saturation via local function; no other sub-modules.
// TESTING (RESP_LAT=1, NREQ=2, instantiate against cache_system_direct)
// 1 Reset: hold rst=0 with req_valid=2'b11 -> req_ready=0, cache_read=0, all stats 0.
// 2 Single req0 addr=0x010 -> cache_read high exactly 1 cycle, rsp_valid=2'b01 3 cycles after accept; first access miss: stat_misses=1, stat_cost=100.
// 3 Repeat addr 0x010 -> rsp_l1_hit=1, stat_l1_hits=1, stat_cost=101.
// 4 Both valid continuously, 4 accesses -> grants 0,1,0,1; rsp_valid alternates 01,10,01,10.
// 5 stat_clear pulsed in RESP cycle -> all stats 0 next cycle, that response still delivered.
// 6 CNT_W=4, 17 L1 hits -> stat_l1_hits stays 15; rst=0 during WAIT -> no rsp_valid, FSM IDLE.

Source files
------------

// File: rtl/cache_req_arbiter_pkg.sv
// Shared types and defaults for the cache request arbiter: FSM encoding,
// access classification and default per-level costs.
package cache_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        CLS_MISS = 2'd0,
        CLS_L1   = 2'd1,
        CLS_L2   = 2'd2
    } hit_cls_t;

    localparam int DEF_ADDR_W   = 11;
    localparam int DEF_L1_COST  = 1;
    localparam int DEF_L2_COST  = 10;
    localparam int DEF_MEM_COST = 100;

    // An L1 hit takes precedence even when the L2 also reports a hit.
    function automatic hit_cls_t classify(input logic l1_hit, input logic l2_hit);
        hit_cls_t cls_v;
        if (l1_hit) begin
            cls_v = CLS_L1;
        end else if (l2_hit) begin
            cls_v = CLS_L2;
        end else begin
            cls_v = CLS_MISS;
        end
        return cls_v;
    endfunction

endpackage

// File: rtl/cache_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester
// found searching upward from pointer+1, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] pointer,
    output logic [NREQ-1:0]  grant
);

    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // Walk the requesters in rotated order, granting the first one asserted.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx_s        = PTR_W'((int'(pointer) + off) % NREQ);
            grant[idx_s] = req[idx_s] & ~found_s;
            found_s      = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache system port between NREQ requesters,
// sequencing read/response and keeping saturating hit/miss/cost statistics.
module cache_req_arbiter
    import cache_req_arbiter_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = 32,
    parameter int RESP_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int COST_W   = 24,
    parameter int L1_COST  = DEF_L1_COST,
    parameter int L2_COST  = DEF_L2_COST,
    parameter int MEM_COST = DEF_MEM_COST
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_l1_hit,
    output logic                   rsp_l2_hit,
    output logic                   cache_read,
    output logic [ADDR_W-1:0]      cache_addr,
    input  logic [DATA_W-1:0]      cache_data,
    input  logic                   cache_l1_hit,
    input  logic                   cache_l2_hit,
    input  logic                   stat_clear,
    output logic [CNT_W-1:0]       stat_l1_hits,
    output logic [CNT_W-1:0]       stat_l2_hits,
    output logic [CNT_W-1:0]       stat_misses,
    output logic [COST_W-1:0]      stat_cost
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LAT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    arb_state_t        state_r, state_s;
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  gnt_idx_r, gnt_idx_s;
    logic [NREQ-1:0]   gnt_s;
    logic [ADDR_W-1:0] addr_sel_s;
    logic [LAT_W-1:0]  wait_cnt_r;
    logic              accept_s;
    logic              cache_read_r;
    logic [ADDR_W-1:0] cache_addr_r;
    logic [NREQ-1:0]   rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_l1_hit_r, rsp_l2_hit_r;
    logic [CNT_W-1:0]  l1_cnt_r, l2_cnt_r, miss_cnt_r;
    logic [COST_W-1:0] cost_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (&val) ? val : val + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [COST_W-1:0] sat_add_cost(input logic [COST_W-1:0] acc,
                                                       input logic [COST_W-1:0] inc);
        logic [COST_W:0] sum_v;
        sum_v = {1'b0, acc} + {1'b0, inc};
        return sum_v[COST_W] ? {COST_W{1'b1}} : sum_v[COST_W-1:0];
    endfunction

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
        .req     (req_valid),
        .pointer (ptr_r),
        .grant   (gnt_s)
    );

    // Grant index and granted address from the one-hot grant.
    always_comb begin
        gnt_idx_s  = '0;
        addr_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_idx_s  = gnt_idx_s | (gnt_s[i] ? PTR_W'(i) : {PTR_W{1'b0}});
            addr_sel_s = addr_sel_s | (gnt_s[i] ? req_addr[i*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}});
        end
    end

    // Ready is only offered in IDLE and is held low throughout reset.
    always_comb begin
        if (state_r == ST_IDLE) begin
            req_ready = gnt_s & {NREQ{rst}};
        end else begin
            req_ready = '0;
        end
        accept_s = |req_ready;
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_r == {LAT_W{1'b0}}) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus cache-side and response-side datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= PTR_W'(NREQ - 1);
            gnt_idx_r    <= '0;
            wait_cnt_r   <= '0;
            cache_read_r <= 1'b0;
            cache_addr_r <= '0;
            rsp_valid_r  <= '0;
            rsp_data_r   <= '0;
            rsp_l1_hit_r <= 1'b0;
            rsp_l2_hit_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cache_read_r <= (state_r == ST_IDLE) && accept_s;
            rsp_valid_r  <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cache_addr_r <= addr_sel_s;
                        gnt_idx_r    <= gnt_idx_s;
                    end
                end
                ST_ISSUE: wait_cnt_r <= LAT_W'(RESP_LAT - 1);
                ST_WAIT: begin
                    if (wait_cnt_r == {LAT_W{1'b0}}) begin
                        rsp_data_r   <= cache_data;
                        rsp_l1_hit_r <= cache_l1_hit;
                        rsp_l2_hit_r <= cache_l2_hit;
                        rsp_valid_r  <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_r;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: ptr_r <= gnt_idx_r;
                default: ptr_r <= ptr_r;
            endcase
        end
    end

    // Statistics: a clear takes priority over the access finishing this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l1_cnt_r   <= '0;
            l2_cnt_r   <= '0;
            miss_cnt_r <= '0;
            cost_r     <= '0;
        end else if (stat_clear) begin
            l1_cnt_r   <= '0;
            l2_cnt_r   <= '0;
            miss_cnt_r <= '0;
            cost_r     <= '0;
        end else if (state_r == ST_RESP) begin
            case (classify(rsp_l1_hit_r, rsp_l2_hit_r))
                CLS_L1: begin
                    l1_cnt_r <= sat_inc(l1_cnt_r);
                    cost_r   <= sat_add_cost(cost_r, COST_W'(L1_COST));
                end
                CLS_L2: begin
                    l2_cnt_r <= sat_inc(l2_cnt_r);
                    cost_r   <= sat_add_cost(cost_r, COST_W'(L2_COST));
                end
                CLS_MISS: begin
                    miss_cnt_r <= sat_inc(miss_cnt_r);
                    cost_r     <= sat_add_cost(cost_r, COST_W'(MEM_COST));
                end
                default: cost_r <= cost_r;
            endcase
        end
    end

    assign cache_read   = cache_read_r;
    assign cache_addr   = cache_addr_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_data     = rsp_data_r;
    assign rsp_l1_hit   = rsp_l1_hit_r;
    assign rsp_l2_hit   = rsp_l2_hit_r;
    assign stat_l1_hits = l1_cnt_r;
    assign stat_l2_hits = l2_cnt_r;
    assign stat_misses  = miss_cnt_r;
    assign stat_cost    = cost_r;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a behavioural cache responder and
// a scoreboard of expected responses pushed at accept and popped at rsp_valid.
module tb_cache_req_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int KW   = 10;
    localparam int CNT_MAX  = 15;
    localparam int COST_MAX = 1023;

    typedef struct {
        logic [1:0]  oh;
        logic [31:0] data;
        logic        l1;
        logic        l2;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [2*AW-1:0] req_addr = '0;
    logic [1:0]      req_ready, rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_l1_hit, rsp_l2_hit, cache_read;
    logic [AW-1:0]   cache_addr;
    logic [DW-1:0]   cache_data;
    logic            cache_l1_v = 1'b0;
    logic            cache_l2_v = 1'b0;
    logic            stat_clear = 1'b0;
    logic [CW-1:0]   stat_l1_hits, stat_l2_hits, stat_misses;
    logic [KW-1:0]   stat_cost;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t last_exp;
    int   grant_log[$];
    int   acc_cyc_log[$];
    int   cyc = 0;
    int   n_acc = 0;
    int   n_rd = 0;
    int   lat_last = 0;
    int   acc_cyc_last = 0;
    logic got_rsp = 1'b0;
    logic resp_now = 1'b0;
    int   m_l1 = 0, m_l2 = 0, m_miss = 0, m_cost = 0;

    cache_req_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RESP_LAT(1),
        .CNT_W(CW), .COST_W(KW), .L1_COST(1), .L2_COST(10), .MEM_COST(100)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_l1_hit(rsp_l1_hit), .rsp_l2_hit(rsp_l2_hit),
        .cache_read(cache_read), .cache_addr(cache_addr),
        .cache_data(cache_data), .cache_l1_hit(cache_l1_v), .cache_l2_hit(cache_l2_v),
        .stat_clear(stat_clear),
        .stat_l1_hits(stat_l1_hits), .stat_l2_hits(stat_l2_hits),
        .stat_misses(stat_misses), .stat_cost(stat_cost)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_data(input logic [AW-1:0] a);
        return {21'd0, a} ^ 32'hA5A5_0000;
    endfunction

    assign cache_data = model_data(cache_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m_l1 = 0; m_l2 = 0; m_miss = 0; m_cost = 0;
    endtask

    // One clock: record accepts, advance stats model, then check after the edge.
    task automatic tick();
        logic [1:0] acc;
        exp_t       e;
        int         idx;
        #1;
        acc = req_valid & req_ready;
        if (acc != 2'b00) begin
            idx    = acc[1] ? 1 : 0;
            e.oh   = acc;
            e.data = model_data(req_addr[idx*AW +: AW]);
            e.l1   = cache_l1_v;
            e.l2   = cache_l2_v;
            sb.push_back(e);
            grant_log.push_back(idx);
            acc_cyc_log.push_back(cyc);
            acc_cyc_last = cyc;
            n_acc++;
        end
        if (stat_clear) begin
            model_zero();
        end else if (resp_now) begin
            if (last_exp.l1) begin
                m_l1   = (m_l1 == CNT_MAX) ? CNT_MAX : m_l1 + 1;
                m_cost = (m_cost + 1 > COST_MAX) ? COST_MAX : m_cost + 1;
            end else if (last_exp.l2) begin
                m_l2   = (m_l2 == CNT_MAX) ? CNT_MAX : m_l2 + 1;
                m_cost = (m_cost + 10 > COST_MAX) ? COST_MAX : m_cost + 10;
            end else begin
                m_miss = (m_miss == CNT_MAX) ? CNT_MAX : m_miss + 1;
                m_cost = (m_cost + 100 > COST_MAX) ? COST_MAX : m_cost + 100;
            end
        end
        resp_now = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        if (cache_read) n_rd++;
        if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {62'd0, rsp_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, e.oh});
                chk("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
                chk("rsp_l1_hit", {63'd0, rsp_l1_hit}, {63'd0, e.l1});
                chk("rsp_l2_hit", {63'd0, rsp_l2_hit}, {63'd0, e.l2});
                last_exp = e;
                resp_now = 1'b1;
                got_rsp  = 1'b1;
                lat_last = cyc - acc_cyc_last;
            end
        end
        chk("stat_l1_hits", 64'(stat_l1_hits), 64'(m_l1));
        chk("stat_l2_hits", 64'(stat_l2_hits), 64'(m_l2));
        chk("stat_misses", 64'(stat_misses), 64'(m_miss));
        chk("stat_cost", 64'(stat_cost), 64'(m_cost));
    endtask

    // Single access from requester r; optionally pulse stat_clear in the RESP cycle.
    task automatic do_access(input int r, input logic [AW-1:0] a, input logic l1,
                             input logic l2, input logic clr_in_resp);
        int n0;
        cache_l1_v = l1;
        cache_l2_v = l2;
        req_addr[r*AW +: AW] = a;
        req_valid = 2'b00;
        req_valid[r] = 1'b1;
        n_rd = 0;
        got_rsp = 1'b0;
        n0 = n_acc;
        tick();
        chk("accept", 64'(n_acc - n0), 64'd1);
        req_valid = 2'b00;
        for (int k = 0; k < 10 && !got_rsp; k++) tick();
        chk("rsp_seen", {63'd0, got_rsp}, 64'd1);
        chk("latency", 64'(lat_last), 64'd3);
        stat_clear = clr_in_resp;
        tick();
        stat_clear = 1'b0;
        chk("cache_read_pulses", 64'(n_rd), 64'd1);
        chk("cache_addr", 64'(cache_addr), 64'(a));
    endtask

    initial begin
        int n0;
        // Reset held with both requesters valid
        rst = 1'b0;
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_cache_read", 64'(cache_read), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_l1", 64'(stat_l1_hits), 64'd0);
        chk("rst_l2", 64'(stat_l2_hits), 64'd0);
        chk("rst_miss", 64'(stat_misses), 64'd0);
        chk("rst_cost", 64'(stat_cost), 64'd0);
        req_valid = 2'b00;
        rst = 1'b1;
        tick();

        // First access misses, repeat hits L1, req1 hits L2 only
        do_access(0, 11'h010, 1'b0, 1'b0, 1'b0);
        chk("t2_misses", 64'(stat_misses), 64'd1);
        chk("t2_cost", 64'(stat_cost), 64'd100);
        do_access(0, 11'h010, 1'b1, 1'b0, 1'b0);
        chk("t3_l1", 64'(stat_l1_hits), 64'd1);
        chk("t3_cost", 64'(stat_cost), 64'd101);
        do_access(1, 11'h3FF, 1'b0, 1'b1, 1'b0);
        chk("t3b_l2", 64'(stat_l2_hits), 64'd1);
        chk("t3b_cost", 64'(stat_cost), 64'd111);

        // Both valid continuously: alternate grants at one access per 4 cycles
        cache_l1_v = 1'b1;
        cache_l2_v = 1'b1;
        req_addr = {11'h030, 11'h020};
        req_valid = 2'b11;
        grant_log.delete();
        acc_cyc_log.delete();
        n0 = n_acc;
        for (int k = 0; k < 40 && (n_acc - n0) < 4; k++) tick();
        req_valid = 2'b00;
        chk("t4_accepts", 64'(n_acc - n0), 64'd4);
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        tick();
        chk("t4_drained", 64'(sb.size()), 64'd0);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            chk($sformatf("t4_grant%0d", k), 64'(grant_log[k]), 64'(k % 2));
        for (int k = 1; k < 4 && k < acc_cyc_log.size(); k++)
            chk($sformatf("t4_spacing%0d", k), 64'(acc_cyc_log[k] - acc_cyc_log[k-1]), 64'd4);
        chk("t4_l1", 64'(stat_l1_hits), 64'd5);
        chk("t4_cost", 64'(stat_cost), 64'd115);

        // Clear in the RESP cycle: response delivered, access not counted
        do_access(1, 11'h123, 1'b0, 1'b0, 1'b1);
        chk("t5_l1", 64'(stat_l1_hits), 64'd0);
        chk("t5_miss", 64'(stat_misses), 64'd0);
        chk("t5_cost", 64'(stat_cost), 64'd0);

        // Cost saturates at all-ones
        for (int k = 0; k < 11; k++) do_access(k % 2, AW'(k), 1'b0, 1'b0, 1'b0);
        chk("sat_cost_miss", 64'(stat_misses), 64'd11);
        chk("sat_cost", 64'(stat_cost), 64'(COST_MAX));
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;

        // Counter saturates at 15 after 17 L1 hits
        for (int k = 0; k < 17; k++) do_access(0, 11'h040, 1'b1, 1'b0, 1'b0);
        chk("sat_l1", 64'(stat_l1_hits), 64'(CNT_MAX));
        chk("sat_l1_cost", 64'(stat_cost), 64'd17);

        // Reset during WAIT aborts the access
        cache_l1_v = 1'b1;
        cache_l2_v = 1'b0;
        req_addr[0 +: AW] = 11'h055;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        chk("abort_wait_read", 64'(cache_read), 64'd0);
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("abort_ready", 64'(req_ready), 64'd0);
        chk("abort_rsp", 64'(rsp_valid), 64'd0);
        chk("abort_l1", 64'(stat_l1_hits), 64'd0);
        sb.delete();
        resp_now = 1'b0;
        model_zero();
        @(posedge clk);
        #1;
        chk("abort_rsp_held", 64'(rsp_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("abort_idle_ptr", 64'(req_ready), 64'd1);
        req_valid = 2'b00;
        for (int k = 0; k < 6; k++) tick();
        chk("abort_no_rsp", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
